// File: rtl/mem_responder.sv
// Tagged-transaction memory responder: hands out transaction tags for load/store
// commands and returns load data a fixed MEM_LATENCY cycles after acceptance.
package mem_responder_pkg;
    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_command_e;
endpackage

module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int MEM_LATENCY = 4,
    parameter int NUM_LINES   = 8192,
    parameter int TAG_COUNT   = 15
) (
    input  logic         clock,
    input  logic         reset,
    input  mem_command_e proc2mem_command,
    input  logic [31:0]  proc2mem_addr,
    input  logic [63:0]  proc2mem_data,
    output logic [3:0]   mem2proc_transaction_tag,
    output logic [63:0]  mem2proc_data,
    output logic [3:0]   mem2proc_data_tag
);
    localparam int LINE_W = $clog2(NUM_LINES);
    localparam int TAG_W  = 4;

    logic [63:0]          mem_q [NUM_LINES];
    logic [TAG_COUNT-1:0] busy_q, busy_d;
    logic [TAG_W-1:0]     ack_tag_q, ack_tag_d;
    logic                 ack_store_q, ack_store_d;
    logic [TAG_W-1:0]     pipe_tag_q [MEM_LATENCY];
    logic [63:0]          pipe_data_q [MEM_LATENCY];
    logic [TAG_W-1:0]     pipe_tag_d;
    logic [63:0]          pipe_data_d;

    logic [LINE_W-1:0]    line_idx;
    logic [TAG_W-1:0]     alloc_tag;
    logic [TAG_W-1:0]     ret_tag;
    logic                 has_cmd;
    logic                 accept;
    logic                 do_store;
    logic                 do_load;
    logic                 unused_addr_bits;

    assign line_idx         = proc2mem_addr[3 +: LINE_W];
    assign unused_addr_bits = ^{proc2mem_addr[31:3+LINE_W], proc2mem_addr[2:0]};
    assign ret_tag          = pipe_tag_q[MEM_LATENCY-1];

    assign has_cmd  = (proc2mem_command == MEM_LOAD) || (proc2mem_command == MEM_STORE);
    assign accept   = has_cmd && (alloc_tag != '0);
    assign do_store = accept && (proc2mem_command == MEM_STORE);
    assign do_load  = accept && (proc2mem_command == MEM_LOAD);

    // Lowest-numbered free tag wins; 0 means every tag is busy.
    always_comb begin
        alloc_tag = '0;
        for (int t = TAG_COUNT; t >= 1; t--) begin
            if (!busy_q[t-1]) alloc_tag = TAG_W'(t);
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        busy_d = busy_q;
        for (int t = 1; t <= TAG_COUNT; t++) begin
            if (ret_tag == TAG_W'(t))                 busy_d[t-1] = 1'b0;
            if (ack_store_q && ack_tag_q == TAG_W'(t)) busy_d[t-1] = 1'b0;
            if (accept && alloc_tag == TAG_W'(t))      busy_d[t-1] = 1'b1;
        end
        ack_tag_d   = accept ? alloc_tag : '0;
        ack_store_d = do_store;
        pipe_tag_d  = do_load ? alloc_tag : '0;
        // Read-at-issue: the line is captured now, so later stores cannot leak in.
        pipe_data_d = do_load ? mem_q[line_idx] : '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            busy_q      <= '0;
            ack_tag_q   <= '0;
            ack_store_q <= 1'b0;
            for (int s = 0; s < MEM_LATENCY; s++) begin
                pipe_tag_q[s]  <= '0;
                pipe_data_q[s] <= '0;
            end
        end else begin
            busy_q         <= busy_d;
            ack_tag_q      <= ack_tag_d;
            ack_store_q    <= ack_store_d;
            pipe_tag_q[0]  <= pipe_tag_d;
            pipe_data_q[0] <= pipe_data_d;
            for (int s = 1; s < MEM_LATENCY; s++) begin
                pipe_tag_q[s]  <= pipe_tag_q[s-1];
                pipe_data_q[s] <= pipe_data_q[s-1];
            end
        end
    end

    // NOTE: the backing store is deliberately not reset; contents survive reset.
    always_ff @(posedge clock) begin
        if (reset && do_store) mem_q[line_idx] <= proc2mem_data;
    end

    assign mem2proc_transaction_tag = ack_tag_q;
    assign mem2proc_data_tag        = ret_tag;
    assign mem2proc_data            = pipe_data_q[MEM_LATENCY-1];

endmodule
